control_fsm: RTL

//  Multi-cycle control unit directly upstream of the register file. Fetches an 8-bit instruction

---
 rtl/control_fsm.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit feeding the register file.
// Optional feature macro SINGLE_STEP_EN adds a 'step' input that gates each instruction fetch.
module control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       imem_req,
  input  logic       imem_valid,
  input  logic [7:0] imem_data,
  input  logic       alu_zero,
  input  logic       mem_ack,
  output logic [1:0] rs_addr,
  output logic [1:0] rt_addr,
  output logic [1:0] wr_addr,
  output logic [2:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       reg_write,
  output logic       beq_ctrl,
  output logic       jr_ctrl,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       halted,
  output logic       err,
  output logic       illegal
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERROR
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] ir_reg, ir_next;
  logic [7:0] mem_cnt_reg, mem_cnt_next;
  logic       zero_reg, zero_next;
  logic       imem_req_reg, imem_req_next;
  logic       fetch_ok_next;
  logic       accept;

  // One-hot opcode decode of the instruction register
  logic [15:0] op_hot;
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_op_dec
      assign op_hot[gi] = (ir_reg[7:4] == 4'(gi));
    end
  endgenerate

  logic is_alu, is_lw, is_sw, is_beq, is_j, is_jr, is_jal, is_halt, is_illegal;
  assign is_alu     = |op_hot[4:0];
  assign is_lw      = op_hot[5];
  assign is_sw      = op_hot[6];
  assign is_beq     = op_hot[8];
  assign is_j       = op_hot[9];
  assign is_jr      = op_hot[10];
  assign is_jal     = op_hot[11];
  assign is_halt    = op_hot[15];
  assign is_illegal = op_hot[7] | op_hot[12] | op_hot[13] | op_hot[14];

  // Instruction is taken only while the request is actually being presented
  assign accept = (state_reg == S_FETCH) & imem_req_reg & imem_valid;

`ifdef SINGLE_STEP_EN
  logic step_pending_reg, step_pending_next;

  // 1-deep memory of a step pulse; consumed when an instruction is accepted
  always_comb begin
    step_pending_next = step | (step_pending_reg & ~accept);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_pending_reg <= 1'b0;
    end else begin
      step_pending_reg <= step_pending_next;
    end
  end

  assign fetch_ok_next = step_pending_next;
`else
  assign fetch_ok_next = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_FETCH;
      ir_reg       <= 8'd0;
      mem_cnt_reg  <= 8'd0;
      zero_reg     <= 1'b0;
      imem_req_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ir_reg       <= ir_next;
      mem_cnt_reg  <= mem_cnt_next;
      zero_reg     <= zero_next;
      imem_req_reg <= imem_req_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ir_next      = ir_reg;
    mem_cnt_next = 8'd0;
    zero_next    = zero_reg;
    case (state_reg)
      S_FETCH: begin
        if (accept) begin
          ir_next    = imem_data;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (is_beq) begin
          zero_next = alu_zero;
        end
        state_next = (is_lw | is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // Ack takes priority over a timeout landing in the same cycle
        mem_cnt_next = mem_cnt_reg + 8'd1;
        if (mem_ack) begin
          state_next = S_WB;
        end else if (mem_cnt_next == TIMEOUT_CNT) begin
          state_next = S_ERROR;
        end
      end
      S_WB: begin
        state_next = S_FETCH;
      end
      S_HALT, S_ERROR: begin
        state_next = state_reg;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
    imem_req_next = (state_next == S_FETCH) & fetch_ok_next;
  end

  always_comb begin
    imem_req  = imem_req_reg;
    rs_addr   = ir_reg[3:2];
    rt_addr   = ir_reg[1:0];
    wr_addr   = is_jal ? 2'b11 : ir_reg[3:2];
    alu_op    = is_alu ? ir_reg[6:4] : 3'd0;
    wb_sel    = 2'd0;
    reg_write = 1'b0;
    beq_ctrl  = 1'b0;
    jr_ctrl   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    halted    = 1'b0;
    err       = 1'b0;
    illegal   = 1'b0;
    if (is_lw) begin
      wb_sel = 2'd1;
    end else if (is_jal) begin
      wb_sel = 2'd2;
    end
    case (state_reg)
      S_DECODE: begin
        illegal = is_illegal;
      end
      S_EXEC: begin
        beq_ctrl = is_beq;
        jr_ctrl  = is_jr;
      end
      S_MEM: begin
        mem_rd = is_lw;
        mem_wr = is_sw;
      end
      S_WB: begin
        reg_write = is_alu | is_lw | is_jal;
        pc_write  = 1'b1;
        if (is_beq) begin
          pc_src = {1'b0, zero_reg};
        end else if (is_j | is_jal) begin
          pc_src = 2'd2;
        end else if (is_jr) begin
          pc_src = 2'd3;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
